// File: rtl/fpu_addsub.sv
// rtl/fpu_addsub.sv - multi-cycle floating-point adder/subtractor, round-to-nearest-even
// One stage per state: capture, align, add/subtract, normalize, round, publish.
module fpu_addsub #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic [1+EXP_W+MAN_W-1:0] op_A_in,
    input  logic [1+EXP_W+MAN_W-1:0] op_B_in,
    output logic                     busy,
    output logic                     done,
    output logic [1+EXP_W+MAN_W-1:0] data_out,
    output logic [3:0]               status_out
);
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int SIG_W   = MAN_W + 1;
    localparam int EXT_W   = SIG_W + 3;
    localparam int SUM_W   = EXT_W + 1;
    localparam int RS_W    = SIG_W + 1;
    localparam int XE_W    = EXP_W + 2;
    localparam int LZ_W    = $clog2(EXT_W + 1);
    localparam int EXP_MAX = 2**EXP_W - 1;

    if (BIAS < 1 || BIAS >= EXP_MAX) begin : g_bias_check
        $error("fpu_addsub: BIAS outside the representable exponent range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_OPERATE, S_NORMALIZE, S_ROUND, S_DONE
    } state_t;

    state_t r_state, w_next_state;

    logic                   r_busy, r_done;
    logic [W-1:0]           r_data_out;
    logic [3:0]             r_status_out;
    logic [W-1:0]           r_a, r_b;
    logic                   r_sub;
    logic                   r_spec;
    logic [W-1:0]           r_spec_res;
    logic [3:0]             r_spec_stat;
    logic [EXT_W-1:0]       r_big, r_small;
    logic                   r_sign_big, r_sign_small;
    logic signed [XE_W-1:0] r_exp;
    logic [SUM_W-1:0]       r_sum;
    logic                   r_sign;
    logic [EXT_W-1:0]       r_norm;
    logic signed [XE_W-1:0] r_nexp;
    logic                   r_zero;
    logic [W-1:0]           r_res;
    logic [3:0]             r_stat;

    logic w_accept;
    assign w_accept = (r_state == S_IDLE) && !r_busy && start;

    always_ff @(posedge clock100KHz) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next_state = S_ALIGN;
            S_ALIGN:     w_next_state = S_OPERATE;
            S_OPERATE:   w_next_state = S_NORMALIZE;
            S_NORMALIZE: w_next_state = S_ROUND;
            S_ROUND:     w_next_state = S_DONE;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_diff;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_sa, w_sb, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_a_big;
    logic [EXT_W-1:0] w_big_ext, w_small_ext, w_small_al, w_lost_mask;

    assign w_ea        = r_a[W-2 -: EXP_W];
    assign w_eb        = r_b[W-2 -: EXP_W];
    assign w_ma        = r_a[MAN_W-1:0];
    assign w_mb        = r_b[MAN_W-1:0];
    assign w_sa        = r_a[W-1];
    assign w_sb        = r_b[W-1] ^ r_sub;
    assign w_a_inf     = &w_ea;
    assign w_b_inf     = &w_eb;
    assign w_a_zero    = ~|w_ea;
    assign w_b_zero    = ~|w_eb;
    assign w_a_big     = (w_ea >= w_eb);
    assign w_e_big     = w_a_big ? w_ea : w_eb;
    assign w_diff      = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_big_ext   = {1'b1, (w_a_big ? w_ma : w_mb), 3'b000};
    assign w_small_ext = {1'b1, (w_a_big ? w_mb : w_ma), 3'b000};

    // Bits shifted past the GRS window collapse into the sticky position.
    always_comb begin
        w_lost_mask = '0;
        w_small_al  = '0;
        if (int'(w_diff) >= MAN_W + 3) begin
            w_small_al[0] = 1'b1;
        end else begin
            w_lost_mask   = (EXT_W'(1) << w_diff) - EXT_W'(1);
            w_small_al    = w_small_ext >> w_diff;
            w_small_al[0] = w_small_al[0] | (|(w_small_ext & w_lost_mask));
        end
    end

    logic         w_spec;
    logic [W-1:0] w_spec_res;
    logic [3:0]   w_spec_stat;

    always_comb begin
        w_spec      = 1'b1;
        w_spec_res  = '0;
        w_spec_stat = 4'b0001;
        if (w_a_inf || w_b_inf) begin
            w_spec_res  = {(w_a_inf ? w_sa : w_sb), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_stat = 4'b0100;
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res  = {w_sa & w_sb, {(W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_spec_res  = {w_sb, r_b[W-2:0]};
        end else if (w_b_zero) begin
            w_spec_res  = r_a;
        end else begin
            w_spec      = 1'b0;
        end
    end

    logic [SUM_W-1:0] w_sum;
    logic             w_sum_sign;

    always_comb begin
        w_sum      = {1'b0, r_big} + {1'b0, r_small};
        w_sum_sign = r_sign_big;
        if (r_sign_big != r_sign_small) begin
            if (r_big >= r_small) begin
                w_sum = {1'b0, r_big - r_small};
            end else begin
                w_sum      = {1'b0, r_small - r_big};
                w_sum_sign = r_sign_small;
            end
        end
    end

    logic [LZ_W-1:0]        w_lzc;
    logic [EXT_W-1:0]       w_norm;
    logic signed [XE_W-1:0] w_norm_exp;

    always_comb begin
        w_lzc = LZ_W'(EXT_W);
        for (int i = 0; i < EXT_W; i++) begin
            if (r_sum[i]) w_lzc = LZ_W'(EXT_W - 1 - i);
        end
    end

    always_comb begin
        w_norm     = r_sum[EXT_W-1:0];
        w_norm_exp = r_exp;
        if (r_sum[SUM_W-1]) begin
            w_norm     = r_sum[SUM_W-1:1];
            w_norm[0]  = r_sum[1] | r_sum[0];
            w_norm_exp = r_exp + XE_W'(1);
        end else begin
            w_norm     = r_sum[EXT_W-1:0] << w_lzc;
            w_norm_exp = r_exp - $signed(XE_W'(w_lzc));
        end
    end

    logic                   w_up, w_inexact, w_rcarry;
    logic [RS_W-1:0]        w_rsig;
    logic [MAN_W-1:0]       w_man_f;
    logic signed [XE_W-1:0] w_exp_f;
    logic [W-1:0]           w_res;
    logic [3:0]             w_stat;

    assign w_up      = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    assign w_inexact = |r_norm[2:0];
    assign w_rsig    = {1'b0, r_norm[EXT_W-1:3]} + RS_W'(w_up);
    assign w_rcarry  = w_rsig[SIG_W];
    assign w_man_f   = w_rcarry ? w_rsig[MAN_W:1] : w_rsig[MAN_W-1:0];
    assign w_exp_f   = r_nexp + (w_rcarry ? XE_W'(1) : XE_W'(0));

    // Overflow outranks underflow, which outranks inexact.
    always_comb begin
        w_res  = {r_sign, w_exp_f[EXP_W-1:0], w_man_f};
        w_stat = w_inexact ? 4'b0010 : 4'b0001;
        if (r_spec) begin
            w_res  = r_spec_res;
            w_stat = r_spec_stat;
        end else if (r_zero) begin
            w_res  = '0;
            w_stat = 4'b0001;
        end else if (int'(w_exp_f) >= EXP_MAX) begin
            w_res  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_stat = 4'b0100;
        end else if (int'(w_exp_f) < 1) begin
            w_res  = {r_sign, {(W-1){1'b0}}};
            w_stat = 4'b1000;
        end
    end

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= op_A_in;
                        r_b   <= op_B_in;
                        r_sub <= op_sub;
                    end
                end
                S_ALIGN: begin
                    r_spec       <= w_spec;
                    r_spec_res   <= w_spec_res;
                    r_spec_stat  <= w_spec_stat;
                    r_big        <= w_big_ext;
                    r_small      <= w_small_al;
                    r_sign_big   <= w_a_big ? w_sa : w_sb;
                    r_sign_small <= w_a_big ? w_sb : w_sa;
                    r_exp        <= {2'b00, w_e_big};
                end
                S_OPERATE: begin
                    r_sum  <= w_sum;
                    r_sign <= w_sum_sign;
                end
                S_NORMALIZE: begin
                    r_norm <= w_norm;
                    r_nexp <= w_norm_exp;
                    r_zero <= (r_sum == '0);
                end
                S_ROUND: begin
                    r_res  <= w_res;
                    r_stat <= w_stat;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_data_out   <= '0;
            r_status_out <= 4'b0001;
        end else begin
            r_done <= (r_state == S_DONE);
            if (w_accept)    r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;
            if (r_state == S_DONE) begin
                r_data_out   <= r_res;
                r_status_out <= r_stat;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign data_out   = r_data_out;
    assign status_out = r_status_out;
endmodule

// File: tb/tb_fpu_addsub.sv
// tb/tb_fpu_addsub.sv - self-checking bench for fpu_addsub
module tb_fpu_addsub;
    logic        clk = 1'b0;
    logic        reset, start, op_sub;
    logic [31:0] a_in, b_in;
    logic        busy, done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_done   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_addsub dut (
        .clock100KHz(clk),
        .reset      (reset),
        .start      (start),
        .op_sub     (op_sub),
        .op_A_in    (a_in),
        .op_B_in    (b_in),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .status_out (status_out)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Exact-arithmetic reference: full-precision sum, then round-to-nearest-even.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] res, output logic [3:0] st);
        int ea, eb, emin, e, p, sh;
        logic sa, sb, neg, inexact;
        logic [127:0] ma, mb, m, q, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:25]);
        eb = int'(b[30:25]);
        if (ea == 63 || eb == 63) begin
            res = {(ea == 63) ? sa : sb, 6'h3f, 25'h0}; st = 4'b0100; return;
        end
        if (ea == 0 && eb == 0) begin res = {sa & sb, 31'h0}; st = 4'b0001; return; end
        if (ea == 0) begin res = {sb, b[30:0]}; st = 4'b0001; return; end
        if (eb == 0) begin res = a; st = 4'b0001; return; end
        emin = (ea < eb) ? ea : eb;
        ma = {102'b0, 1'b1, a[24:0]} << (ea - emin);
        mb = {102'b0, 1'b1, b[24:0]} << (eb - emin);
        if (sa == sb)      begin m = ma + mb; neg = sa; end
        else if (ma >= mb) begin m = ma - mb; neg = sa; end
        else               begin m = mb - ma; neg = sb; end
        if (m == 0) begin res = 32'h0; st = 4'b0001; return; end
        p = 127;
        while (!m[p]) p--;
        e = emin + p - 25;
        inexact = 1'b0;
        if (p > 25) begin
            sh   = p - 25;
            q    = m >> sh;
            rem  = m & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
            if (q[26]) begin q = q >> 1; e++; end
        end else begin
            q = m << (25 - p);
        end
        if (e >= 63)    begin res = {neg, 6'h3f, 25'h0}; st = 4'b0100; end
        else if (e < 1) begin res = {neg, 31'h0}; st = 4'b1000; end
        else begin
            res = {neg, e[5:0], q[24:0]};
            st  = inexact ? 4'b0010 : 4'b0001;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("data_out", data_out, e.res);
                check("status_out", 32'(status_out), 32'(e.st));
                check("latency", 32'(cyc - e.acc_cyc), 32'd5);
                check("busy_during_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin @(negedge clk); k++; end
        if (busy !== 1'b0) begin
            n_checks++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, k);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && k < 60) begin @(negedge clk); k++; end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: %0d results missing after %0d cycles, required 0", name, exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [31:0] r;
        logic [3:0]  s;
        wait_idle("idle_before_start");
        model(a, b, sub, r, s);
        a_in = a; b_in = b; op_sub = sub; start = 1'b1;
        e.res = r; e.st = s; e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  s;
        int          nd0;
        reset = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;

        vecs[0]  = '{32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001};
        vecs[1]  = '{32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001};
        vecs[2]  = '{32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0100};
        vecs[3]  = '{32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010};
        vecs[4]  = '{32'h02000000, 32'h02000001, 1'b1, 32'h80000000, 4'b1000};
        vecs[5]  = '{32'h7E000000, 32'h3E000000, 1'b1, 32'h7E000000, 4'b0100};
        vecs[6]  = '{32'h00000000, 32'h3E000000, 1'b1, 32'hBE000000, 4'b0001};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001};
        vecs[8]  = '{32'h3F000000, 32'h3E000000, 1'b0, 32'h40800000, 4'b0001};
        vecs[9]  = '{32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0010};
        vecs[10] = '{32'h3E000000, 32'h3C000000, 1'b1, 32'h3C000000, 4'b0001};
        vecs[11] = '{32'h3E000000, 32'h04000000, 1'b1, 32'h3E000000, 4'b0010};
        vecs[12] = '{32'hC0000000, 32'h3E000000, 1'b0, 32'hBE000000, 4'b0001};
        vecs[13] = '{32'h3E000001, 32'h3E000000, 1'b1, 32'h0C000000, 4'b0001};

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data_out", data_out, 32'h0);
        check("reset_status_out", 32'(status_out), 32'h1);
        reset = 1'b0;

        foreach (vecs[i]) begin
            model(vecs[i].a, vecs[i].b, vecs[i].sub, r, s);
            check($sformatf("vec%0d_model_res", i), r, vecs[i].res);
            check($sformatf("vec%0d_model_st", i), 32'(s), 32'(vecs[i].st));
        end

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sub);
        drain("directed_drain");

        for (int i = 0; i < 16; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain("random_drain");

        nd0 = n_done;
        run_op(32'h3F000000, 32'h3E000000, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (busy !== 1'b1) break;
            start = 1'b1; a_in = $urandom; b_in = $urandom; op_sub = ~op_sub;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("repulse_single_done", 32'(n_done - nd0), 32'd1);
        drain("repulse_drain");

        run_op(32'h3E000000, 32'h3E000000, 1'b0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b1; start = 1'b1; a_in = 32'h3E000000; b_in = 32'h3E000000; op_sub = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("midop_reset_done", 32'(done), 32'd0);
        check("midop_reset_busy", 32'(busy), 32'd0);
        check("midop_reset_data_out", data_out, 32'h0);
        check("midop_reset_status_out", 32'(status_out), 32'h1);
        @(negedge clk);
        check("start_with_reset_dropped", 32'(busy), 32'd0);
        nd0 = n_done;
        repeat (10) @(negedge clk);
        check("no_done_after_reset", 32'(n_done - nd0), 32'd0);

        run_op(32'h3E000000, 32'h3E000000, 1'b0);
        drain("post_reset_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
